// File: rtl/sprite_blit_pkg.sv
// ---------------------------------------------------------------------------
// sprite_blit_pkg
// Shared definitions for the sprite blitter and its scan counter.
//   blit_state_t      : blitter FSM state encoding
//   COLOR_TRANSPARENT : default colour key that is never plotted
//   COLOR_BLACK       : colour the adapter outputs start from
//   ROM_LATENCY       : read latency of the sprite ROM in cycles
// ---------------------------------------------------------------------------
package sprite_blit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } blit_state_t;

  localparam logic [2:0] COLOR_TRANSPARENT = 3'b101;
  localparam logic [2:0] COLOR_BLACK       = 3'b000;
  localparam int unsigned ROM_LATENCY      = 1;

endpackage

// File: rtl/sprite_scan_counter.sv
// ---------------------------------------------------------------------------
// sprite_scan_counter
// Raster-order x/y counter over a SPR_W x SPR_H texel grid (x fastest).
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : synchronous return to (0,0), wins over i_enable
//   i_enable       : advance one texel
//   o_x, o_y       : current texel address
//   o_last         : high while the address is (SPR_W-1, SPR_H-1)
// ---------------------------------------------------------------------------
module sprite_scan_counter #(
  parameter int SPR_W    = 10,
  parameter int SPR_H    = 6,
  parameter int WIDTH_SX = 4,
  parameter int WIDTH_SY = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_enable,
  output logic [WIDTH_SX-1:0] o_x,
  output logic [WIDTH_SY-1:0] o_y,
  output logic                o_last
);

  localparam logic [WIDTH_SX-1:0] X_MAX = WIDTH_SX'(SPR_W - 1);
  localparam logic [WIDTH_SY-1:0] Y_MAX = WIDTH_SY'(SPR_H - 1);

  logic [WIDTH_SX-1:0] r_x;
  logic [WIDTH_SY-1:0] r_y;
  logic                w_x_end;

  assign w_x_end = (r_x == X_MAX);
  assign o_last  = w_x_end && (r_y == Y_MAX);
  assign o_x     = r_x;
  assign o_y     = r_y;

  // After the last texel the counter wraps to (0,0) so the next draw
  // starts from the origin without needing an explicit clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_enable) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= o_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
// Walks every texel of one sprite ROM, translates it to screen coordinates at
// a latched origin and drives the VGA adapter write port. Clipped and
// transparent texels still take their cycle, so draw time is fixed.
// Ports:
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_start                 : draw request, honoured only when idle
//   i_pos_x, i_pos_y        : sprite origin, latched on an accepted start
//   o_spr_x, o_spr_y        : sprite ROM address
//   i_spr_color             : ROM data, one cycle behind the address
//   o_vga_x/y/color/plot    : adapter write port (registered)
//   o_busy                  : high in every state but idle
//   o_done                  : one-cycle pulse at the end of a draw
// ---------------------------------------------------------------------------
module sprite_blitter
  import sprite_blit_pkg::*;
#(
  parameter int         SPR_W       = 10,
  parameter int         SPR_H       = 6,
  parameter int         WIDTH_SX    = 4,
  parameter int         WIDTH_SY    = 3,
  parameter int         SCREEN_X    = 160,
  parameter int         SCREEN_Y    = 120,
  parameter int         WIDTH_X     = 8,
  parameter int         WIDTH_Y     = 7,
  parameter logic [2:0] TRANSPARENT = COLOR_TRANSPARENT,
  parameter bit         TRANSP_EN   = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [WIDTH_X-1:0]  i_pos_x,
  input  logic [WIDTH_Y-1:0]  i_pos_y,
  output logic [WIDTH_SX-1:0] o_spr_x,
  output logic [WIDTH_SY-1:0] o_spr_y,
  input  logic [2:0]          i_spr_color,
  output logic [WIDTH_X-1:0]  o_vga_x,
  output logic [WIDTH_Y-1:0]  o_vga_y,
  output logic [2:0]          o_vga_color,
  output logic                o_vga_plot,
  output logic                o_busy,
  output logic                o_done
);

  localparam int SXW = WIDTH_X + 1;
  localparam int SYW = WIDTH_Y + 1;
  localparam logic [SXW-1:0] SX_LIMIT   = SXW'(SCREEN_X);
  localparam logic [SYW-1:0] SY_LIMIT   = SYW'(SCREEN_Y);
  localparam logic [1:0]     DRAIN_LAST = 2'(ROM_LATENCY);

  blit_state_t         r_state;
  logic [WIDTH_X-1:0]  r_pos_x;
  logic [WIDTH_Y-1:0]  r_pos_y;
  logic [1:0]          r_drain;
  logic                r_busy;
  logic                r_done;

  logic [WIDTH_SX-1:0] r_stage_x;
  logic [WIDTH_SY-1:0] r_stage_y;
  logic                r_stage_v;

  logic [WIDTH_X-1:0]  r_vga_x;
  logic [WIDTH_Y-1:0]  r_vga_y;
  logic [2:0]          r_vga_color;
  logic                r_vga_plot;

  logic [WIDTH_SX-1:0] w_spr_x;
  logic [WIDTH_SY-1:0] w_spr_y;
  logic                w_last;
  logic                w_accept;
  logic [SXW-1:0]      w_sx;
  logic [SYW-1:0]      w_sy;
  logic                w_opaque;
  logic                w_plot;

  assign w_accept = (r_state == ST_IDLE) && i_start;

  sprite_scan_counter #(
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .WIDTH_SX(WIDTH_SX),
    .WIDTH_SY(WIDTH_SY)
  ) u_scan (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_accept),
    .i_enable(r_state == ST_FETCH),
    .o_x     (w_spr_x),
    .o_y     (w_spr_y),
    .o_last  (w_last)
  );

  // Sums are one bit wider than the screen coordinates so a sprite hanging
  // off the right/bottom edge is clipped instead of wrapping to 0.
  assign w_sx     = {1'b0, r_pos_x} + SXW'(r_stage_x);
  assign w_sy     = {1'b0, r_pos_y} + SYW'(r_stage_y);
  assign w_opaque = !(TRANSP_EN && (i_spr_color == TRANSPARENT));
  assign w_plot   = r_stage_v && (w_sx < SX_LIMIT) && (w_sy < SY_LIMIT) && w_opaque;

  // Control FSM: FETCH for one cycle per texel, DRAIN for the ROM stage and
  // the output register, then a single DONE cycle before returning to IDLE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_pos_x <= i_pos_x;
            r_pos_y <= i_pos_y;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_last) begin
            r_drain <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address stage lines up with the ROM data; the output register only
  // loads on a plot so the adapter sees stable values between writes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stage_x   <= '0;
      r_stage_y   <= '0;
      r_stage_v   <= 1'b0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= COLOR_BLACK;
      r_vga_plot  <= 1'b0;
    end else begin
      r_stage_x  <= w_spr_x;
      r_stage_y  <= w_spr_y;
      r_stage_v  <= (r_state == ST_FETCH);
      r_vga_plot <= w_plot;
      if (w_plot) begin
        r_vga_x     <= w_sx[WIDTH_X-1:0];
        r_vga_y     <= w_sy[WIDTH_Y-1:0];
        r_vga_color <= i_spr_color;
      end
    end
  end

  assign o_spr_x     = w_spr_x;
  assign o_spr_y     = w_spr_y;
  assign o_vga_x     = r_vga_x;
  assign o_vga_y     = r_vga_y;
  assign o_vga_color = r_vga_color;
  assign o_vga_plot  = r_vga_plot;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Consumer-side counterpart of the sprite ROM and coordinate-scan path.
- On a start request, walks every texel of one sprite ROM, reads its colour (1-cycle synchronous ROM latency), translates it to screen coordinates at a latched origin, and drives the VGA adapter write port (x, y, colour, plot).
- Sits between the game-logic draw scheduler and the vga_adapter; one blitter instance per sprite ROM.

Parameters:
- SPR_W, 10, sprite width in texels
- SPR_H, 6, sprite height in texels
- WIDTH_SX, 4, sprite x address width
- WIDTH_SY, 3, sprite y address width
- SCREEN_X, 160, screen width in pixels
- SCREEN_Y, 120, screen height in pixels
- WIDTH_X, 8, screen x width
- WIDTH_Y, 7, screen y width
- TRANSPARENT, 3'b101, colour never plotted
- TRANSP_EN, 1, 1 = skip TRANSPARENT texels

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  draw request; sampled only in IDLE
- pos_x  in  WIDTH_X  screen x of sprite origin (top-left); latched on accepted start
- pos_y  in  WIDTH_Y  screen y of origin; latched on accepted start
- spr_x  out  WIDTH_SX  sprite ROM x address
- spr_y  out  WIDTH_SY  sprite ROM y address
- spr_color  in  3  ROM data; valid 1 cycle after spr_x/spr_y
- vga_x  out  WIDTH_X  screen x to adapter
- vga_y  out  WIDTH_Y  screen y to adapter
- vga_color  out  3  colour to adapter
- vga_plot  out  1  adapter write enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of draw

Behaviour:
- Reset (asynchronous, any time including mid-draw): state=IDLE; spr_x, spr_y, vga_x, vga_y, vga_color = 0; vga_plot, busy, done = 0; pipeline valid bits cleared; the in-progress draw is abandoned with no done pulse.
- N = SPR_W*SPR_H. Cycle 0 = the cycle in which start is sampled high in IDLE.
- FSM states:
  - IDLE: addresses held at 0. start=1 -> latch pos_x/pos_y, go to FETCH.
  - FETCH: cycles 1..N. Presents texel k = spr_y*SPR_W + spr_x in cycle k+1, in raster order (x fastest). Wrap: x==SPR_W-1 -> x=0, y+1. Address (SPR_W-1, SPR_H-1) -> DRAIN next cycle; addresses return to 0.
  - DRAIN: cycles N+1, N+2. Flushes the ROM stage and output register.
  - DONE: cycle N+3. done=1, busy=1 -> IDLE.
- Pipeline: the address stage carries (spr_x, spr_y, valid) one cycle to align with spr_color. Outputs are registered, so texel k appears on vga_* in cycle k+3.
- Screen coordinate computation:
  - sx = pos_x + spr_x, computed WIDTH_X+1 bits wide, no truncation.
  - sy = pos_y + spr_y, computed WIDTH_Y+1 bits wide, no truncation.
- vga_plot=1 only when all of these hold: stage valid, sx < SCREEN_X, sy < SCREEN_Y, and !(TRANSP_EN && spr_color==TRANSPARENT).
- Clipped or transparent texels still occupy their cycle, so timing is independent of content and position.
- When vga_plot=0, vga_x, vga_y and vga_color hold their previous values.
- start while busy (including the DONE cycle): ignored; pos not re-latched. Minimum start-to-start period is N+4 cycles.
- busy=1 from cycle 1 through cycle N+3 inclusive. done=1 only in cycle N+3.

Decomposition:
- Package sprite_blit_pkg: state encoding (IDLE, FETCH, DRAIN, DONE), default colour constants (TRANSPARENT, BLACK), ROM latency constant (1).
- Sub-module sprite_scan_counter: raster x/y counter with clear, enable and a "last" flag asserted on (SPR_W-1, SPR_H-1). Reusable by other scan-based blocks.
- Top level contains the FSM, the alignment pipeline, clip/transparency logic and output registers.

Test Plan:
- SPR_W=2, SPR_H=2, ROM {1,2,3,4}, start with pos=(10,20) -> plots (10,20,1), (11,20,2), (10,21,3), (11,21,4) in cycles 3..6; done=1 only in cycle 7; busy high in cycles 1..7.
- Default 10x6 sprite, ROM texel (3,2)=TRANSPARENT, TRANSP_EN=1 -> exactly 59 plots, no write at (pos_x+3, pos_y+2), done in cycle 63; with TRANSP_EN=0 -> 60 plots.
- Default sprite, pos=(155,117) -> only texels with x<5 and y<3 plot (15 writes), no wrap to x=0 or y=0; done still in cycle 63.
- start pulsed in cycles 5 and 63 with a different pos -> both ignored, all writes use the first pos; a start in cycle 64 (IDLE) is accepted.
- Reset asserted asynchronously in cycle 20 -> vga_plot, busy, done drop to 0 immediately; state is IDLE; no done pulse; a fresh start afterwards draws the full sprite correctly.
- pos=(159,119) with SPR_W=1, SPR_H=1 -> single plot at (159,119); pos=(160,0) -> zero plots, done still pulses in cycle 4.
